// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through FIFO with a ready/valid write port.
// Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign din_ready = !rst && (fifo_count != FULL);
  assign push      = din_valid && din_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  state_t               state, state_n;
  logic [15:0]          baud, baud_n;
  logic [3:0]           bit_idx, bit_n;
  logic                 stop_idx, stop_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 tx_n, done_n;
  logic                 bit_end, load;

  assign bit_end = (baud == BAUD_LAST);
  assign tx_busy = (state != S_IDLE);

  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud + 16'd1;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    shreg_n = shreg;
    par_n   = par_bit;
    tx_n    = tx;
    done_n  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        load   = (fifo_count != '0);
      end
      S_START: if (bit_end) begin
        tx_n    = shreg[0];
        bit_n   = '0;
        state_n = S_DATA;
      end
      S_DATA: if (bit_end) begin
        if (bit_idx == BIT_LAST) begin
          if (PARITY != 0) begin
            tx_n    = par_bit;
            state_n = S_PAR;
          end else begin
            tx_n    = 1'b1;
            stop_n  = 1'b0;
            state_n = S_STOP;
          end
        end else begin
          shreg_n = shreg >> 1;
          tx_n    = shreg[1];
          bit_n   = bit_idx + 4'd1;
        end
      end
      S_PAR: if (bit_end) begin
        tx_n    = 1'b1;
        stop_n  = 1'b0;
        state_n = S_STOP;
      end
      S_STOP: if (bit_end) begin
        if (stop_idx == STOP_LAST) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
          load    = (fifo_count != '0);
        end else begin
          stop_n = stop_idx + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Loading from IDLE and from the final stop edge share one path so frames chain gaplessly.
    if (load) begin
      pop     = 1'b1;
      shreg_n = head;
      par_n   = (PARITY == 1) ? ~^head : ^head;
      tx_n    = 1'b0;
      baud_n  = '0;
      state_n = S_START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      stop_idx <= stop_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      tx       <= tx_n;
      tx_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations checked every cycle against a queue/frame model,
// plus directed frames with hand-computed bit patterns and timings.
module tb_uart_tx_fifo;

  localparam int NDUT = 4;
  localparam int CD  [NDUT] = '{4, 4, 3, 2};
  localparam int DB  [NDUT] = '{8, 7, 5, 8};
  localparam int PAR [NDUT] = '{0, 2, 0, 1};
  localparam int SB  [NDUT] = '{1, 2, 1, 1};
  localparam int DEP [NDUT] = '{4, 8, 4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [NDUT];
  logic [8:0] din       [NDUT];
  logic       din_valid [NDUT];
  logic       din_ready [NDUT];
  logic       tx        [NDUT];
  logic       tx_busy   [NDUT];
  logic       tx_done   [NDUT];
  logic [2:0] cnt0;
  logic [3:0] cnt1;
  logic [2:0] cnt2;
  logic [1:0] cnt3;
  logic [31:0] cntv [NDUT];

  always_comb begin
    cntv[0] = 32'(cnt0);
    cntv[1] = 32'(cnt1);
    cntv[2] = 32'(cnt2);
    cntv[3] = 32'(cnt3);
  end

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst[0]), .din(din[0][7:0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .fifo_count(cnt0));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .rst(rst[1]), .din(din[1][6:0]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .fifo_count(cnt1));
  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst[2]), .din(din[2][4:0]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
    .tx(tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .fifo_count(cnt2));
  uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u3 (
    .clk(clk), .rst(rst[3]), .din(din[3][7:0]), .din_valid(din_valid[3]), .din_ready(din_ready[3]),
    .tx(tx[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]), .fifo_count(cnt3));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int flen_of(input int i);
    return (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i]) * CD[i];
  endfunction

  // Line level of every bit slot of one frame, slot 0 = start bit; unused high slots stay 1 (stop).
  function automatic logic [15:0] frame_of(input int i, input logic [8:0] w);
    logic [15:0] f = '1;
    logic p = 1'b0;
    int n = 1;
    f[0] = 1'b0;
    for (int b = 0; b < DB[i]; b++) begin
      f[n] = w[b];
      p ^= w[b];
      n++;
    end
    if (PAR[i] == 1) f[n] = ~p;
    else if (PAR[i] == 2) f[n] = p;
    return f;
  endfunction

  logic [8:0]  mq   [NDUT][$];
  bit          act  [NDUT];
  bit          mdone[NDUT];
  int          pos  [NDUT];
  logic [15:0] fr   [NDUT];
  int          done_cnt [NDUT];
  int          cyc = 0;
  bit          armed = 1'b0;

  initial begin
    int pre;
    logic exp_tx;
    for (int i = 0; i < NDUT; i++) begin
      act[i] = 1'b0; mdone[i] = 1'b0; pos[i] = 0; fr[i] = '1; done_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NDUT; i++) begin
        mdone[i] = 1'b0;
        if (rst[i] === 1'b1) begin
          mq[i].delete();
          act[i] = 1'b0;
          pos[i] = 0;
        end else begin
          pre = mq[i].size();
          if (act[i]) begin
            if (pos[i] + 1 == flen_of(i)) begin
              mdone[i] = 1'b1;
              act[i] = 1'b0;
            end else begin
              pos[i]++;
            end
          end
          if (!act[i] && pre != 0) begin
            fr[i] = frame_of(i, mq[i].pop_front());
            act[i] = 1'b1;
            pos[i] = 0;
          end
          if (din_valid[i] === 1'b1 && pre < DEP[i]) mq[i].push_back(din[i]);
        end
      end
      if (rst[0] === 1'b1) armed = 1'b1;
      @(negedge clk);
      if (armed) begin
        for (int i = 0; i < NDUT; i++) begin
          exp_tx = act[i] ? fr[i][pos[i] / CD[i]] : 1'b1;
          check($sformatf("dut%0d tx", i), 32'(tx[i]), 32'(exp_tx));
          check($sformatf("dut%0d tx_busy", i), 32'(tx_busy[i]), 32'(act[i]));
          check($sformatf("dut%0d tx_done", i), 32'(tx_done[i]), 32'(mdone[i]));
          check($sformatf("dut%0d fifo_count", i), cntv[i], 32'(mq[i].size()));
          check($sformatf("dut%0d din_ready", i), 32'(din_ready[i]),
                32'(rst[i] == 1'b0 && mq[i].size() < DEP[i]));
          if (tx_done[i] === 1'b1) done_cnt[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while ((tx_busy[i] !== 1'b0 || cntv[i] != 0) && t < 3000) begin
      tick();
      t++;
    end
    check($sformatf("dut%0d idle within bound", i), 32'(t < 3000), 1);
    tick();
  endtask

  task automatic frame_check(input int i, input logic [8:0] w, input logic [15:0] expb, input int flen);
    bit early = 1'b0;
    wait_idle(i);
    din[i] = w;
    din_valid[i] = 1'b1;
    tick();
    din_valid[i] = 1'b0;
    check($sformatf("dut%0d count after write", i), cntv[i], 1);
    check($sformatf("dut%0d tx idle at write edge", i), 32'(tx[i]), 1);
    tick();
    check($sformatf("dut%0d tx falls one clock later", i), 32'(tx[i]), 0);
    check($sformatf("dut%0d busy at start", i), 32'(tx_busy[i]), 1);
    for (int c = 0; c < flen; c++) begin
      if (c % CD[i] == 0)
        check($sformatf("dut%0d bit slot %0d", i, c / CD[i]), 32'(tx[i]), 32'(expb[c / CD[i]]));
      if (tx_done[i] === 1'b1) early = 1'b1;
      tick();
    end
    check($sformatf("dut%0d no early tx_done", i), 32'(early), 0);
    check($sformatf("dut%0d tx_done at frame end", i), 32'(tx_done[i]), 1);
    check($sformatf("dut%0d busy drops with tx_done", i), 32'(tx_busy[i]), 0);
  endtask

  initial begin
    logic [8:0] words [5];
    int n, t, acc55, first_done, base;
    bit acc, sawfull, txlow;
    words = '{9'h11, 9'h22, 9'h33, 9'h44, 9'h55};

    for (int i = 0; i < NDUT; i++) begin
      rst[i] = 1'b1; din_valid[i] = 1'b0; din[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d reset tx", i), 32'(tx[i]), 1);
      check($sformatf("dut%0d reset busy", i), 32'(tx_busy[i]), 0);
      check($sformatf("dut%0d reset done", i), 32'(tx_done[i]), 0);
      check($sformatf("dut%0d reset count", i), cntv[i], 0);
      check($sformatf("dut%0d ready low in reset", i), 32'(din_ready[i]), 0);
      rst[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < NDUT; i++)
      check($sformatf("dut%0d ready after reset", i), 32'(din_ready[i]), 1);
    tick();

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    frame_check(0, 9'h0A5, 16'h034A, 40);
    // 7E2 0x07: start, 1110000, parity 1, stop 1,1
    frame_check(1, 9'h007, 16'h070E, 44);
    // 5N1 0x1B: start, 11011, stop
    frame_check(2, 9'h01B, 16'h0076, 21);
    // 8O1 0x07 at CLK_DIV=2: start, 11100000, parity 0, stop
    frame_check(3, 9'h007, 16'h040E, 22);

    // Back-to-back with FIFO filling behind a frame in flight.
    wait_idle(0);
    base = done_cnt[0];
    din[0] = 9'h0A5;
    din_valid[0] = 1'b1;
    tick();
    n = 0; t = 0; acc55 = 0; first_done = 0; sawfull = 1'b0;
    din[0] = words[0];
    while (n < 5 && t < 400) begin
      acc = din_ready[0];
      if (!acc) sawfull = 1'b1;
      tick();
      t++;
      if (tx_done[0] === 1'b1 && first_done == 0) first_done = cyc;
      if (acc) begin
        if (n == 4) acc55 = cyc;
        n++;
        if (n < 5) din[0] = words[n];
      end
    end
    din_valid[0] = 1'b0;
    check("full: all words accepted", 32'(n), 5);
    check("full: ready dropped", 32'(sawfull), 1);
    check("full: 0x55 accepted edge after first pop", 32'(acc55), 32'(first_done + 1));
    wait_idle(0);
    check("full: tx_done pulses", 32'(done_cnt[0] - base), 6);

    // Write landing exactly on the pop edge.
    wait_idle(0);
    base = done_cnt[0];
    din[0] = 9'h03C;
    din_valid[0] = 1'b1;
    tick();
    din[0] = 9'h05A;
    tick();
    din_valid[0] = 1'b0;
    check("pushpop: count at start edge", cntv[0], 1);
    repeat (39) tick();
    din[0] = 9'h096;
    din_valid[0] = 1'b1;
    tick();
    din_valid[0] = 1'b0;
    check("pushpop: tx_done on pop edge", 32'(tx_done[0]), 1);
    check("pushpop: count unchanged", cntv[0], 1);
    check("pushpop: next start bit", 32'(tx[0]), 0);
    wait_idle(0);
    check("pushpop: tx_done pulses", 32'(done_cnt[0] - base), 3);

    // Reset during data bit 3 with two words queued.
    wait_idle(0);
    base = done_cnt[0];
    din[0] = 9'h081; din_valid[0] = 1'b1; tick();
    din[0] = 9'h042; tick();
    din[0] = 9'h024; tick();
    din_valid[0] = 1'b0;
    check("reset: queued words", cntv[0], 2);
    repeat (15) tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("reset: tx high", 32'(tx[0]), 1);
    check("reset: count flushed", cntv[0], 0);
    check("reset: busy low", 32'(tx_busy[0]), 0);
    check("reset: no done", 32'(tx_done[0]), 0);
    txlow = 1'b0;
    repeat (100) begin
      tick();
      if (tx[0] !== 1'b1) txlow = 1'b1;
    end
    check("reset: line stays idle", 32'(txlow), 0);
    check("reset: aborted frame has no done", 32'(done_cnt[0] - base), 0);

    // Random traffic with occasional resets on every configuration.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NDUT; i++) begin
        din_valid[i] = ($urandom_range(0, 2) == 0);
        din[i] = 9'($urandom);
        rst[i] = ($urandom_range(0, 399) == 0);
      end
      tick();
    end
    for (int i = 0; i < NDUT; i++) begin
      din_valid[i] = 1'b0;
      rst[i] = 1'b0;
    end
    for (int i = 0; i < NDUT; i++) wait_idle(i);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
